// File: rtl/apb_master_sched.sv
// Shares one APB master port between NUM_MASTERS requesters: round-robin grant, paddr slave
// decode, SETUP/ACCESS sequencing, response mux and a wait-state timeout.
module apb_master_sched #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int DATA_LENGTH = 32,
    parameter int SEL_LSB     = 12,
    parameter int TIMEOUT     = 16
) (
    input  logic                               pclk,
    input  logic                               preset,
    input  logic [NUM_MASTERS-1:0]             req_valid,
    output logic [NUM_MASTERS-1:0]             req_ready,
    input  logic [NUM_MASTERS*DATA_LENGTH-1:0] req_addr,
    input  logic [NUM_MASTERS-1:0]             req_write,
    input  logic [NUM_MASTERS*DATA_LENGTH-1:0] req_wdata,
    input  logic [NUM_MASTERS*4-1:0]           req_strb,
    input  logic [NUM_MASTERS*3-1:0]           req_prot,
    output logic [NUM_MASTERS-1:0]             rsp_valid,
    output logic [DATA_LENGTH-1:0]             rsp_rdata,
    output logic                               rsp_err,
    output logic [DATA_LENGTH-1:0]             paddr,
    output logic [2:0]                         pprot,
    output logic [NUM_SLAVES-1:0]              psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [DATA_LENGTH-1:0]             pwdata,
    output logic [3:0]                         pstrb,
    input  logic [NUM_SLAVES-1:0]              pready,
    input  logic [NUM_SLAVES*DATA_LENGTH-1:0]  prdata,
    input  logic [NUM_SLAVES-1:0]              pslverr
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int DW = DATA_LENGTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                 state_q;
    logic                   run_q;
    logic [MW-1:0]          ptr_q;
    logic [MW-1:0]          owner_q;
    logic [IW-1:0]          sel_idx_q;
    logic [CW-1:0]          wait_cnt_q;
    logic [DW-1:0]          paddr_q;
    logic [DW-1:0]          pwdata_q;
    logic [DW-1:0]          rsp_rdata_q;
    logic [2:0]             pprot_q;
    logic [3:0]             pstrb_q;
    logic                   pwrite_q;
    logic                   penable_q;
    logic                   rsp_err_q;
    logic [NUM_SLAVES-1:0]  psel_q;
    logic [NUM_MASTERS-1:0] rsp_valid_q;

    logic                   gnt_found_s;
    logic                   gnt_fire_s;
    logic [MW-1:0]          gnt_idx_s;
    int                     cand_s;
    logic [NUM_MASTERS-1:0] req_ready_s;
    logic [DW-1:0]          sel_addr_s;
    logic [DW-1:0]          sel_wdata_s;
    logic                   sel_write_s;
    logic [3:0]             sel_strb_s;
    logic [2:0]             sel_prot_s;
    logic [IW-1:0]          dec_idx_s;
    logic                   dec_ok_s;
    logic                   pready_sel_s;
    logic                   pslverr_sel_s;
    logic [DW-1:0]          prdata_sel_s;

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        cand_s      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand_s      = (int'(ptr_q) + k) % NUM_MASTERS;
            gnt_idx_s   = (req_valid[MW'(cand_s)] && !gnt_found_s) ? MW'(cand_s) : gnt_idx_s;
            gnt_found_s = gnt_found_s | req_valid[MW'(cand_s)];
        end
    end

    // Acceptance pulse; run_q keeps it quiet until the first clock after reset release.
    always_comb begin
        gnt_fire_s  = run_q && (state_q == IDLE) && gnt_found_s;
        req_ready_s = '0;
        if (gnt_fire_s) begin
            req_ready_s[gnt_idx_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    // Fields of the requester being granted.
    always_comb begin
        sel_addr_s  = req_addr[int'(gnt_idx_s)*DW +: DW];
        sel_wdata_s = req_wdata[int'(gnt_idx_s)*DW +: DW];
        sel_strb_s  = req_strb[int'(gnt_idx_s)*4 +: 4];
        sel_prot_s  = req_prot[int'(gnt_idx_s)*3 +: 3];
        sel_write_s = req_write[gnt_idx_s];
    end

    if (NUM_SLAVES > 1) begin : g_dec_field
        assign dec_idx_s = sel_addr_s[SEL_LSB +: IW];
    end else begin : g_dec_single
        assign dec_idx_s = '0;
    end
    assign dec_ok_s = (int'(dec_idx_s) < NUM_SLAVES);

    // Response mux from the slave selected by the transfer in flight.
    always_comb begin
        pready_sel_s  = pready[sel_idx_q];
        pslverr_sel_s = pslverr[sel_idx_q];
        prdata_sel_s  = prdata[int'(sel_idx_q)*DW +: DW];
    end

    // Transfer sequencer; all APB and response outputs are registered here.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            ptr_q       <= '0;
            owner_q     <= '0;
            sel_idx_q   <= '0;
            wait_cnt_q  <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pprot_q     <= 3'b000;
            pstrb_q     <= 4'b0000;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            psel_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (gnt_fire_s) begin
                        owner_q    <= gnt_idx_s;
                        wait_cnt_q <= '0;
                        if (dec_ok_s) begin
                            sel_idx_q <= dec_idx_s;
                            paddr_q   <= sel_addr_s;
                            pwrite_q  <= sel_write_s;
                            pwdata_q  <= sel_wdata_s;
                            pstrb_q   <= sel_write_s ? sel_strb_s : 4'b0000;
                            pprot_q   <= sel_prot_s;
                            psel_q    <= NUM_SLAVES'(1'b1) << dec_idx_s;
                            state_q   <= SETUP;
                        end else begin
                            // Unmapped slave index: answer with an error, bus untouched.
                            rsp_valid_q <= NUM_MASTERS'(1'b1) << gnt_idx_s;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_sel_s) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= NUM_MASTERS'(1'b1) << owner_q;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata_sel_s;
                        rsp_err_q   <= pslverr_sel_s;
                        state_q     <= RESP;
                    end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= NUM_MASTERS'(1'b1) << owner_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    ptr_q       <= (owner_q == MW'(NUM_MASTERS - 1)) ? '0 : owner_q + 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign paddr     = paddr_q;
    assign pprot     = pprot_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;

    apb_master_sched_chk #(
        .NUM_MASTERS (NUM_MASTERS),
        .NUM_SLAVES  (NUM_SLAVES)
    ) u_chk (
        .pclk      (pclk),
        .preset    (preset),
        .psel      (psel_q),
        .penable   (penable_q),
        .rsp_valid (rsp_valid_q),
        .req_ready (req_ready_s)
    );

endmodule

// Protocol invariants of the scheduler outputs.
module apb_master_sched_chk #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4
) (
    input logic                   pclk,
    input logic                   preset,
    input logic [NUM_SLAVES-1:0]  psel,
    input logic                   penable,
    input logic [NUM_MASTERS-1:0] rsp_valid,
    input logic [NUM_MASTERS-1:0] req_ready
);

    a_psel_onehot0: assert property (@(posedge pclk) disable iff (preset) $onehot0(psel));
    a_penable_sel: assert property (@(posedge pclk) disable iff (preset) penable |-> (psel != '0));
    a_rsp_onehot0: assert property (@(posedge pclk) disable iff (preset) $onehot0(rsp_valid));
    a_rdy_onehot0: assert property (@(posedge pclk) disable iff (preset) $onehot0(req_ready));

endmodule

// File: doc/apb_master_sched.md
Name: apb_master_sched

Overview:
- Shares one APB master port between NUM_MASTERS internal requesters, such as the x2p bridge front-end and a debug/DMA port.
- Arbitrates round-robin and decodes paddr into a one-hot psel.
- Sequences the APB SETUP/ACCESS phases, muxes the selected slave's response back, and enforces a wait-state timeout.
- Drives signals matching the master_s_type/slave_s_type fields from apb_package: paddr, pprot, penable, pwrite, pwdata, pstrb / pready, prdata, pslverr.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- NUM_SLAVES, 4, number of APB slaves (1..16).
- DATA_LENGTH, 32, address and data width.
- SEL_LSB, 12, lowest paddr bit of the slave index field; the field is clog2(NUM_SLAVES) bits wide.
- TIMEOUT, 16, maximum ACCESS cycles with pready low before forced error (≥2).

Ports:
- pclk  in  1  clock.
- preset  in  1  asynchronous active-high reset.
- req_valid  in  NUM_MASTERS  request pending, per requester.
- req_ready  out  NUM_MASTERS  request accepted this cycle (one-hot or 0).
- req_addr  in  NUM_MASTERS*DATA_LENGTH  per-requester address.
- req_write  in  NUM_MASTERS  1=write.
- req_wdata  in  NUM_MASTERS*DATA_LENGTH  write data.
- req_strb  in  NUM_MASTERS*4  byte strobes.
- req_prot  in  NUM_MASTERS*3  protection.
- rsp_valid  out  NUM_MASTERS  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_LENGTH  read data, shared, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- paddr  out  DATA_LENGTH  APB address.
- pprot  out  3  APB prot.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB write.
- pwdata  out  DATA_LENGTH  APB write data.
- pstrb  out  4  APB strobes (0 on reads).
- pready  in  NUM_SLAVES  per-slave ready.
- prdata  in  NUM_SLAVES*DATA_LENGTH  per-slave read data.
- pslverr  in  NUM_SLAVES  per-slave error.

Behaviour:
- Interface: single clock pclk; preset is asynchronous, active-high.
- Reset value of all outputs is 0. FSM resets to IDLE and the round-robin pointer resets to requester 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid, grant the first valid requester at or after the pointer (wrapping).
  - Pulse req_ready[g] for that cycle.
  - Register addr, write, wdata, strb (forced to 0 if read) and prot.
  - Decode idx = addr[SEL_LSB +: clog2(NUM_SLAVES)].
  - If idx < NUM_SLAVES, go to SETUP. Otherwise flag a decode error and go to RESP without touching the bus.
- SETUP (1 cycle): psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot driven from the registers. Next state is ACCESS.
- ACCESS:
  - psel[idx]=1, penable=1; all APB outputs are held stable.
  - The wait counter increments each cycle while pready[idx]=0.
  - If pready[idx]=1: capture prdata[idx] (reads only; writes return 0) and pslverr[idx], then go to RESP.
  - If the counter reaches TIMEOUT-1 with pready low: set err=1, rdata=0, go to RESP.
  - The bus is released in the next cycle regardless of slave state.
- RESP (1 cycle): psel=0, penable=0. rsp_valid[g]=1 with rsp_rdata and rsp_err. The pointer advances to g+1 mod NUM_MASTERS. Next state is IDLE.
- Latency: a zero-wait transfer takes 4 cycles from the grant cycle to rsp_valid (grant, SETUP, ACCESS, RESP). Throughput is one transfer per 4+waits cycles; there is no back-to-back SETUP.
- Requester rules: req_* must remain stable while req_valid=1 and not yet accepted. Deasserting req_valid before req_ready is allowed, and that request is ignored.
- Simultaneous requests: only one is granted per IDLE visit. Losers keep req_valid and are served in round-robin order, so no requester starves; worst-case wait is NUM_MASTERS-1 transfers.
- psel is always one-hot or zero; penable=1 only in ACCESS.
- Responses from unselected slaves (pready/pslverr/prdata) are ignored.
- Reset mid-operation: all outputs drop to 0 asynchronously. The in-flight transfer is abandoned with no rsp_valid, and the pointer returns to 0.
- NUM_SLAVES=1: the index field is zero-width; every address decodes to slave 0.

Test Plan:
1. Single read: master0 reads 0x0000_2004; slave2 returns pready=1 on the first ACCESS cycle with prdata=0xDEADBEEF -> psel=4'b0100 for 2 cycles, penable high in cycle 2 only, rsp_valid[0] 4 cycles after grant, rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Write with 3 wait states to slave1, strb=4'b0011 -> pstrb=0011 and pwdata stable over 4 ACCESS cycles; rsp_valid[0] on cycle 7 after grant; rsp_err=0.
3. Contention: both masters hold req_valid continuously for 4 transfers -> grants alternate 0,1,0,1; each rsp_valid goes only to its owner.
4. Timeout: slave0 holds pready=0 -> exactly 16 ACCESS cycles, then rsp_err=1 with rsp_rdata=0 and psel released; the next request proceeds normally.
5. Decode error and pslverr:
   - NUM_SLAVES=3, address index 3 -> no psel asserted; rsp_err=1 two cycles after grant.
   - Slave with pslverr=1 and pready=1 -> rsp_err=1.
6. Reset mid-ACCESS: assert preset during wait states -> psel/penable/rsp_valid go to 0 immediately; after release, the first grant goes to master0.
